// File: rtl/ahb3lite_req_arbiter.sv
// ahb3lite_req_arbiter
// Two-client request arbiter and AHB3-Lite master sequencer. Each accepted
// request becomes one SINGLE/NONSEQ transfer. Its completion returns to the
// requesting client as a one-cycle registered response pulse.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin arbitration between the two clients
//              undefined -> fixed priority, client 0 wins
module ahb3lite_req_arbiter #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESET,

    // client side
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*HADDR_SIZE-1:0] req_addr,
    input  logic [1:0]              req_write,
    input  logic [5:0]              req_size,
    input  logic [2*HDATA_SIZE-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic                    rsp_err,
    output logic [HDATA_SIZE-1:0]   rsp_rdata,

    // AHB3-Lite master
    output logic                    HSEL,
    output logic [HADDR_SIZE-1:0]   HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [1:0]              HTRANS,
    output logic [HDATA_SIZE-1:0]   HWDATA,
    input  logic [HDATA_SIZE-1:0]   HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ADDR = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;
    localparam logic [1:0] ST_LERR = 2'b11;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    logic [1:0]            state;
    logic [1:0]            grant;
    logic                  handshake;
    logic                  illegal;
    logic [HADDR_SIZE-1:0] sel_addr;
    logic [2:0]            sel_size;
    logic                  sel_write;
    logic [HDATA_SIZE-1:0] sel_wdata;

    logic                  owner;
    logic [HADDR_SIZE-1:0] lat_addr;
    logic                  lat_write;
    logic [2:0]            lat_size;
    logic [HDATA_SIZE-1:0] lat_wdata;

`ifdef ARB_RR_EN
    // Client favoured when both clients request (0 or 1).
    logic                  rr_ptr;
`endif

    // Pick one winner among the asserted requests.
    always_comb begin
        grant = 2'b00;
`ifdef ARB_RR_EN
        if (req_valid == 2'b11) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req_valid;
        end
`else
        if (req_valid[0]) begin
            grant = 2'b01;
        end else begin
            grant = req_valid;
        end
`endif
    end

    // Offer ready only to the winner, only when idle and out of reset.
    always_comb begin
        req_ready = 2'b00;
        if (state == ST_IDLE && !HRESET) begin
            req_ready = grant;
        end
    end

    assign handshake = |(req_valid & req_ready);

    // Select the winning client's request fields and check their alignment.
    always_comb begin
        sel_addr  = grant[1] ? req_addr[2*HADDR_SIZE-1:HADDR_SIZE] : req_addr[HADDR_SIZE-1:0];
        sel_size  = grant[1] ? req_size[5:3] : req_size[2:0];
        sel_write = grant[1] ? req_write[1] : req_write[0];
        sel_wdata = grant[1] ? req_wdata[2*HDATA_SIZE-1:HDATA_SIZE] : req_wdata[HDATA_SIZE-1:0];
        illegal   = (sel_size > 3'b010)
                 || (sel_size == 3'b001 && sel_addr[0])
                 || (sel_size == 3'b010 && sel_addr[1:0] != 2'b00);
    end

    // Transfer sequencing: IDLE -> ADDR -> DATA -> IDLE, or IDLE -> LERR -> IDLE.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        state <= illegal ? ST_LERR : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // HREADY=0 covers both plain wait states and the first error cycle.
                    if (HREADY) begin
                        state <= ST_IDLE;
                    end
                end
                ST_LERR: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the accepted request; it drives the bus for the whole transfer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner     <= 1'b0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= '0;
            lat_wdata <= '0;
        end else if (handshake) begin
            owner     <= grant[1];
            lat_addr  <= sel_addr;
            lat_write <= sel_write;
            lat_size  <= sel_size;
            lat_wdata <= sel_wdata;
        end
    end

    // Registered completion pulse to the latched owner.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 2'b00;
            if (state == ST_IDLE && handshake && illegal) begin
                // The local error response is issued on entry so it is
                // visible during the single LERR cycle.
                rsp_valid <= grant;
                rsp_err   <= 1'b1;
            end else if (state == ST_DATA && HREADY) begin
                rsp_valid <= owner ? 2'b10 : 2'b01;
                rsp_err   <= HRESP;
                rsp_rdata <= HRDATA;
            end
        end
    end

`ifdef ARB_RR_EN
    // Favour the client that was not granted last; move only on a handshake.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rr_ptr <= 1'b0;
        end else if (handshake) begin
            rr_ptr <= grant[0];
        end
    end
`endif

    // Bus outputs: a single address phase, with no pipelined overlap.
    always_comb begin
        HSEL   = (state == ST_ADDR);
        HTRANS = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        HADDR  = lat_addr;
        HWRITE = lat_write;
        HSIZE  = lat_size;
        HWDATA = lat_wdata;
        HBURST = HBURST_SINGLE;
        HPROT  = HPROT_DATA;
    end

endmodule
